code_rom_arbiter: RTL

CODE_ROM_ARBITER -- requirements
Module: code_rom_arbiter

---
 rtl/rom_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 45 ++++
 rtl/code_rom_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
// Shared types and constants for the code ROM arbiter.
package rom_pkg;

  // Which requester a grant or round-robin pointer refers to.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_sel_e;

  // Default ROM geometry: 2**12 words of 32 bits, addressed by 64-bit byte addresses.
  localparam int ROM_SIZE_LOG2  = 12;
  localparam int ROM_DATA_WIDTH = 32;
  localparam int ROM_ADDR_WIDTH = 64;

  // Contention counter width and saturation value.
  localparam int                   CNT_WIDTH = 32;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  // The requester that is not p.
  function automatic port_sel_e other_port(input port_sel_e p);
    return (p == PORT_IF) ? PORT_LS : PORT_IF;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter between the fetch and load requesters.
// Fetch requests can be blocked for a cycle; a blocked fetch does not count
// as contention and leaves the pointer where it was.
module rr_arbiter2
  import rom_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      req_if,
  input  logic      req_ls,
  input  logic      block_if,
  output logic      gnt_if,
  output logic      gnt_ls,
  output logic      contended,
  output port_sel_e prio
);

  logic req_if_eff;

  assign req_if_eff = req_if & ~block_if;
  assign contended  = req_if_eff & req_ls;

  // Grant: the pointer decides contended cycles, otherwise the lone requester wins.
  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (contended) begin
      gnt_if = (prio == PORT_IF);
      gnt_ls = (prio == PORT_LS);
    end else begin
      gnt_if = req_if_eff;
      gnt_ls = req_ls;
    end
  end

  // Pointer state: after each contended cycle it moves to the side that lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PORT_LS;
    end else if (contended) begin
      prio <= other_port(prio);
    end
  end

endmodule

// File: rtl/code_rom_arbiter.sv
// Shares one combinational code ROM between the fetch (IF) and load (LS) ports.
//
// Handshake: a request transfers in the cycle where req_valid and req_ready are
// both high; the requester keeps valid and address stable until then, and the
// arbiter holds no request storage. ready is a pure function of this cycle's
// grant. The response for a request accepted in cycle N is presented in cycle
// N+1 for exactly one cycle and cannot be stalled.
//
// flush_i redirects fetch: it blocks the fetch grant in its own cycle, so no
// fetch response can follow it. Loads are unaffected.
module code_rom_arbiter
  import rom_pkg::*;
#(
  parameter int                   ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int                   DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int                   ROM_SIZE   = ROM_SIZE_LOG2,
  // Value the contention counter takes in reset; 0 in normal use.
  parameter logic [CNT_WIDTH-1:0] CNT_INIT   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // fetch request / response
  input  logic                  if_req_valid_i,
  output logic                  if_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] if_rsp_data_o,
  output logic                  if_rsp_err_o,
  // load request / response
  input  logic                  ls_req_valid_i,
  output logic                  ls_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  output logic                  ls_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] ls_rsp_data_o,
  output logic                  ls_rsp_err_o,
  // fetch redirect
  input  logic                  flush_i,
  // combinational ROM
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  rom_illegal_i,
  // contention statistics
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  // Byte-address bits at and above this position lie outside the ROM.
  localparam int RANGE_LSB = ROM_SIZE + 2;

  logic                  gnt_if;
  logic                  gnt_ls;
  logic                  contended;
  port_sel_e             rr_prio;
  logic                  out_of_range;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  rr_arbiter2 u_rr (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .req_if    (if_req_valid_i),
    .req_ls    (ls_req_valid_i),
    .block_if  (flush_i),
    .gnt_if    (gnt_if),
    .gnt_ls    (gnt_ls),
    .contended (contended),
    .prio      (rr_prio)
  );

  // Nobody is accepted while the block is held in reset.
  assign if_req_ready_o = rst_ni & gnt_if;
  assign ls_req_ready_o = rst_ni & gnt_ls;

  // ROM address follows the grant; idle cycles present address 0.
  always_comb begin
    rom_addr_o = '0;
    if (gnt_ls) begin
      rom_addr_o = ls_addr_i;
    end else if (gnt_if) begin
      rom_addr_o = if_addr_i;
    end
  end

  // An access errors when the ROM flags it or the address is beyond the ROM.
  assign out_of_range = |rom_addr_o[ADDR_WIDTH-1:RANGE_LSB];
  assign rsp_err      = rom_illegal_i | out_of_range;
  assign rsp_data     = rsp_err ? '0 : rom_data_i;

  // Fetch response register: one-cycle pulse for each fetch grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_rsp_valid_o <= 1'b0;
      if_rsp_data_o  <= '0;
      if_rsp_err_o   <= 1'b0;
    end else begin
      if_rsp_valid_o <= gnt_if;
      if (gnt_if) begin
        if_rsp_data_o <= rsp_data;
        if_rsp_err_o  <= rsp_err;
      end
    end
  end

  // Load response register: one-cycle pulse for each load grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ls_rsp_valid_o <= 1'b0;
      ls_rsp_data_o  <= '0;
      ls_rsp_err_o   <= 1'b0;
    end else begin
      ls_rsp_valid_o <= gnt_ls;
      if (gnt_ls) begin
        ls_rsp_data_o <= rsp_data;
        ls_rsp_err_o  <= rsp_err;
      end
    end
  end

  // Saturating count of cycles where both ports competed for the ROM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_o <= CNT_INIT;
    end else if (contended && (conflict_cnt_o != CNT_MAX)) begin
      conflict_cnt_o <= conflict_cnt_o + CNT_WIDTH'(1);
    end
  end

  // Every contended cycle must hand priority to the other side.
  a_rr_toggles : assert property (@(posedge clk_i) disable iff (!rst_ni)
    contended |=> (rr_prio != $past(rr_prio)));

endmodule
